// File: rtl/cpu_regfile_pkg.sv
// Shared types and default sizes for the CPU general-purpose register file.
// Default (non-bypass) build leaves GPR_BYPASS_EN undefined.
package cpu_regfile_pkg;

    localparam int GPR_DATA_W   = 32;
    localparam int GPR_ADDR_W   = 5;
    localparam int GPR_LINK_REG = 31;

    typedef enum logic [1:0] {
        DST_RT   = 2'b00,
        DST_RD   = 2'b01,
        DST_LINK = 2'b10,
        DST_NONE = 2'b11
    } dst_sel_e;

    typedef enum logic {
        SCRUB = 1'b0,
        READY = 1'b1
    } scrub_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for multi-cycle producers; a reserve beats a
// same-cycle clear so the newest producer owns the register.
module regfile_scoreboard #(
    parameter int ADDR_W        = 5,
    parameter int DEPTH         = 2**ADDR_W,
    parameter int HARDWIRE_ZERO = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              busy_a,
    output logic              busy_b
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    // Indices at or above DEPTH never match a bit, so they are dropped here.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
            if (gi == 0 && HARDWIRE_ZERO != 0) begin : g_zero
                assign pending_d[gi] = 1'b0;
            end else begin : g_bit
                logic set_hit;
                logic clr_hit;
                assign set_hit = set_en && (set_addr == ADDR_W'(gi));
                assign clr_hit = clr_en && (clr_addr == ADDR_W'(gi));
                assign pending_d[gi] = set_hit | (pending_q[gi] & ~clr_hit);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign busy_a = ({1'b0, rd_addr_a} < DEPTH_X) ? pending_q[rd_addr_a] : 1'b0;
    assign busy_b = ({1'b0, rd_addr_b} < DEPTH_X) ? pending_q[rd_addr_b] : 1'b0;

endmodule

// File: rtl/gpr_file_sb.sv
// 2R/1W register file with destination mux, pending scoreboard and post-reset scrub.
// Optional same-cycle write-to-read forwarding: define GPR_BYPASS_EN.
module gpr_file_sb
    import cpu_regfile_pkg::*;
#(
    parameter int DATA_W        = GPR_DATA_W,
    parameter int ADDR_W        = GPR_ADDR_W,
    parameter int DEPTH         = 2**ADDR_W,
    parameter int LINK_REG      = DEPTH-1,
    parameter int HARDWIRE_ZERO = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        dst_sel,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              ready
);

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);
    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

    // True for an index that maps to a real, writable/readable entry.
    function automatic logic idx_live(input logic [ADDR_W-1:0] idx);
        return ({1'b0, idx} < DEPTH_X) && !(HARDWIRE_ZERO != 0 && idx == '0);
    endfunction

    scrub_state_e      state_q, state_d;
    logic [ADDR_W-1:0] scrub_idx_q, scrub_idx_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_idx;
    logic              wr_sel_ok;
    logic              wr_fire;
    logic              rsv_fire;
    logic [DATA_W-1:0] arr_a, arr_b;
    logic              sb_busy_a, sb_busy_b;

    always_comb begin
        state_d     = state_q;
        scrub_idx_d = scrub_idx_q;
        if (state_q == SCRUB) begin
            scrub_idx_d = scrub_idx_q + 1'b1;
            if (scrub_idx_q == LAST_IDX) begin
                state_d     = READY;
                scrub_idx_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCRUB;
            scrub_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            scrub_idx_q <= scrub_idx_d;
        end
    end

    assign ready = (state_q == READY);

    always_comb begin
        wr_idx    = rt_addr;
        wr_sel_ok = 1'b1;
        case (dst_sel_e'(dst_sel))
            DST_RT:   wr_idx = rt_addr;
            DST_RD:   wr_idx = rd_addr;
            DST_LINK: wr_idx = LINK_IDX;
            default:  wr_sel_ok = 1'b0;
        endcase
    end

    assign wr_fire  = ready && wr_en && wr_sel_ok && idx_live(wr_idx);
    assign rsv_fire = ready && rsv_en;

    // Scrub owns the write port until the file is ready.
    always_ff @(posedge clk) begin
        if (state_q == SCRUB) begin
            mem_q[scrub_idx_q] <= '0;
        end else if (wr_fire) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .ADDR_W        (ADDR_W),
        .DEPTH         (DEPTH),
        .HARDWIRE_ZERO (HARDWIRE_ZERO)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .clr_en    (wr_fire),
        .clr_addr  (wr_idx),
        .set_en    (rsv_fire),
        .set_addr  (rsv_addr),
        .rd_addr_a (rs_addr),
        .rd_addr_b (rt_addr),
        .busy_a    (sb_busy_a),
        .busy_b    (sb_busy_b)
    );

    assign arr_a = (ready && idx_live(rs_addr)) ? mem_q[rs_addr] : '0;
    assign arr_b = (ready && idx_live(rt_addr)) ? mem_q[rt_addr] : '0;

`ifdef GPR_BYPASS_EN
    logic byp_a, byp_b;
    assign byp_a = wr_fire && (wr_idx == rs_addr);
    assign byp_b = wr_fire && (wr_idx == rt_addr);

    assign rd_data_a = byp_a ? wr_data : arr_a;
    assign rd_data_b = byp_b ? wr_data : arr_b;
    // A forwarded value is not pending unless a new producer claims it now.
    assign busy_a = ready && (byp_a ? (rsv_en && rsv_addr == rs_addr) : sb_busy_a);
    assign busy_b = ready && (byp_b ? (rsv_en && rsv_addr == rt_addr) : sb_busy_b);
`else
    assign rd_data_a = arr_a;
    assign rd_data_b = arr_b;
    assign busy_a    = ready && sb_busy_a;
    assign busy_b    = ready && sb_busy_b;
`endif

endmodule

// File: tb/tb_gpr_file_sb.sv
// Directed bench for gpr_file_sb: scrub timing, destination mux, zero register,
// scoreboard set/clear, same-cycle read/write and mid-operation reset.
module tb_gpr_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_addr, rt_addr, rd_addr, rsv_addr;
    logic [1:0]  dst_sel;
    logic        wr_en, rsv_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data_a, rd_data_b;
    logic        busy_a, busy_b, ready;

    int checks   = 0;
    int failures = 0;

    gpr_file_sb dut (
        .clk       (clk),
        .reset     (reset),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rd_addr   (rd_addr),
        .dst_sel   (dst_sel),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    // Counts ready=0 cycles after reset has just been dropped.
    task automatic scrub_wait(input string tag);
        int n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (ready) break;
            n++;
        end
        idle();
        check_eq(tag, n, 32);
        step();
    endtask

    // ORs every register value and pending bit across both read ports.
    task automatic sweep_zero(input string tag);
        logic [31:0] acc_d = '0;
        logic [31:0] acc_b = '0;
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            acc_d = acc_d | rd_data_a | rd_data_b;
            acc_b = acc_b | {30'b0, busy_a, busy_b};
        end
        check_eq({tag, "_data"}, acc_d, 32'h0);
        check_eq({tag, "_busy"}, acc_b, 32'h0);
    endtask

    initial begin
        reset = 1'b1; rs_addr = 5'd0; rt_addr = 5'd0; rd_addr = 5'd0; rsv_addr = 5'd0;
        dst_sel = 2'b00; wr_data = '0;
        idle();

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", {31'b0, ready}, 32'h0);
        check_eq("rst_data", rd_data_a, 32'h0);
        reset = 1'b0;
        scrub_wait("scrub_cycles");
        check_eq("ready_after_scrub", {31'b0, ready}, 32'h1);
        sweep_zero("scrub");

        // Destination select: RT, RD, LINK, then reserved code.
        rt_addr = 5'd5; rd_addr = 5'd9; wr_en = 1'b1;
        dst_sel = 2'b00; wr_data = 32'hDEADBEEF; step();
        dst_sel = 2'b01; wr_data = 32'h12345678; step();
        dst_sel = 2'b10; wr_data = 32'h00400010; step();
        dst_sel = 2'b11; wr_data = 32'hBAD0BAD0; step();
        idle();
        rs_addr = 5'd5; rt_addr = 5'd9; #1;
        check_eq("dst_rt", rd_data_a, 32'hDEADBEEF);
        check_eq("dst_rd", rd_data_b, 32'h12345678);
        rs_addr = 5'd31; #1;
        check_eq("dst_link", rd_data_a, 32'h00400010);

        // Hardwired zero.
        wr_en = 1'b1; dst_sel = 2'b00; rt_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0; step();
        idle();
        rs_addr = 5'd0; #1;
        check_eq("zero_data", rd_data_a, 32'h0);
        check_eq("zero_busy", {31'b0, busy_a}, 32'h0);

        // Scoreboard: reserve then write reg7.
        rt_addr = 5'd7; rsv_en = 1'b1; rsv_addr = 5'd7; #1;
        check_eq("rsv_same_cycle", {31'b0, busy_b}, 32'h0);
        step();
        idle();
        check_eq("rsv_next_cycle", {31'b0, busy_b}, 32'h1);
        wr_en = 1'b1; dst_sel = 2'b00; wr_data = 32'h00000077; #1;
`ifdef GPR_BYPASS_EN
        check_eq("wr_busy_same", {31'b0, busy_b}, 32'h0);
`else
        check_eq("wr_busy_same", {31'b0, busy_b}, 32'h1);
`endif
        step();
        idle();
        check_eq("wr_busy_after", {31'b0, busy_b}, 32'h0);
        check_eq("wr_data_r7", rd_data_b, 32'h00000077);

        // Same-cycle write and reserve of reg7.
        wr_en = 1'b1; wr_data = 32'h11112222; rsv_en = 1'b1; rsv_addr = 5'd7; step();
        idle();
        check_eq("wr_rsv_data", rd_data_b, 32'h11112222);
        check_eq("wr_rsv_busy", {31'b0, busy_b}, 32'h1);

        // Write-after-read on reg3 (previously 0).
        rs_addr = 5'd3; rt_addr = 5'd3; wr_en = 1'b1; wr_data = 32'hA5A5A5A5; #1;
`ifdef GPR_BYPASS_EN
        check_eq("war_same", rd_data_a, 32'hA5A5A5A5);
`else
        check_eq("war_same", rd_data_a, 32'h0);
`endif
        step();
        idle();
        check_eq("war_next", rd_data_a, 32'hA5A5A5A5);

        // Mid-operation reset; writes/reserves held active through the scrub.
        rsv_en = 1'b1; rsv_addr = 5'd12; step();
        idle();
        rs_addr = 5'd12; #1;
        check_eq("pre_reset_busy", {31'b0, busy_a}, 32'h1);
        reset = 1'b1; step();
        check_eq("mid_rst_ready", {31'b0, ready}, 32'h0);
        check_eq("mid_rst_data", rd_data_b, 32'h0);
        reset = 1'b0;
        wr_en = 1'b1; dst_sel = 2'b00; rt_addr = 5'd2; wr_data = 32'h0000CAFE;
        rsv_en = 1'b1; rsv_addr = 5'd4;
        scrub_wait("rescrub_cycles");
        sweep_zero("rescrub");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
